// File: rtl/x_encoder_arbiter_pkg.sv
// Shared defaults and width helpers for the X_encoder request arbiter.
// Result word layout everywhere: {x_enc, id} with id in the low bits.
package x_encoder_arbiter_pkg;

  localparam int unsigned DTYPE_SIZE_DEF  = 32;
  localparam int unsigned X_ENC_SIZE_DEF  = 3;
  localparam int unsigned NUM_REQ_DEF     = 2;
  localparam int unsigned ENC_LATENCY_DEF = 2;
  localparam int unsigned FIFO_DEPTH_DEF  = 4;

  // Width of an id/pointer field that must be at least one bit wide.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold fifo_count + in-flight tags without overflow.
  function automatic int unsigned credit_width(input int unsigned depth,
                                               input int unsigned stages);
    return $clog2(depth + stages + 1);
  endfunction

endpackage

// File: rtl/enc_result_fifo.sv
// Synchronous result FIFO with occupancy count; pointers wrap mod DEPTH.
module enc_result_fifo
  import x_encoder_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign valid    = (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/x_encoder_arbiter.sv
// Round-robin, credit-gated sharing of one X_encoder between NUM_REQ requesters;
// tags ride alongside the encoder pipeline and results drain through a FIFO.
module x_encoder_arbiter
  import x_encoder_arbiter_pkg::*;
#(
  parameter int unsigned DTYPE_SIZE  = DTYPE_SIZE_DEF,
  parameter int unsigned X_ENC_SIZE  = X_ENC_SIZE_DEF,
  parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter int unsigned ENC_LATENCY = ENC_LATENCY_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned ID_W        = clog2_min1(NUM_REQ)
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*DTYPE_SIZE*X_ENC_SIZE-1:0] req_x,
  output logic [DTYPE_SIZE*X_ENC_SIZE-1:0]        enc_x,
  input  logic [X_ENC_SIZE-1:0]                   enc_x_enc,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [X_ENC_SIZE-1:0]                   out_x_enc,
  output logic [ID_W-1:0]                         out_id,
  output logic                                    busy
);

  localparam int unsigned VEC_W  = DTYPE_SIZE * X_ENC_SIZE;
  localparam int unsigned STAGES = ENC_LATENCY + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRED_W = credit_width(FIFO_DEPTH, STAGES);
  localparam int unsigned RES_W  = X_ENC_SIZE + ID_W;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   lo_grant;
  logic              hi_found;
  logic              lo_found;
  logic              accept;
  logic              can_issue;
  logic [VEC_W-1:0]  sel_x;
  logic [STAGES-1:0] tag_valid;
  logic [ID_W-1:0]   tag_id [STAGES];
  logic [CRED_W-1:0] inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [RES_W-1:0]  fifo_head;
  logic              pop;

  // First requester at or after rr_ptr wins; otherwise wrap to the lowest index.
  always_comb begin
    grant    = '0;
    lo_grant = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !hi_found && (ID_W'(i) >= rr_ptr)) begin
        grant    = ID_W'(i);
        hi_found = 1'b1;
      end
      if (req_valid[i] && !lo_found) begin
        lo_grant = ID_W'(i);
        lo_found = 1'b1;
      end
    end
    if (!hi_found) grant = lo_grant;
  end

  // Same-cycle pops are not credited, so a result slot is always reserved.
  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      inflight = inflight + CRED_W'(tag_valid[k]);
    end
  end

  assign can_issue = (CRED_W'(fifo_count) + inflight) < CRED_W'(FIFO_DEPTH);
  assign accept    = can_issue && (|req_valid);

  always_comb begin
    req_ready = '0;
    sel_x     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_x        = req_x[i*VEC_W +: VEC_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enc_x     <= '0;
      rr_ptr    <= '0;
      tag_valid <= '0;
      for (int unsigned k = 0; k < STAGES; k++) tag_id[k] <= '0;
    end else begin
      tag_valid <= {tag_valid[STAGES-2:0], accept};
      tag_id[0] <= grant;
      for (int unsigned k = 1; k < STAGES; k++) tag_id[k] <= tag_id[k-1];
      if (accept) begin
        enc_x  <= sel_x;
        rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  assign pop = out_valid && out_ready;

  enc_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (tag_valid[STAGES-1]),
    .push_data ({enc_x_enc, tag_id[STAGES-1]}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .valid     (out_valid),
    .count     (fifo_count)
  );

  assign out_x_enc = fifo_head[ID_W +: X_ENC_SIZE];
  assign out_id    = fifo_head[ID_W-1:0];
  assign busy      = (|tag_valid) || (fifo_count != '0);

endmodule

// File: tb/tb_x_encoder_arbiter.sv
// Scoreboard bench: behavioural two-stage X_encoder (splits 1.0, 0.5, 2.0)
// around the arbiter; expected results queued at accept, checked at pop.
module tb_x_encoder_arbiter;

  localparam int unsigned DTYPE_SIZE  = 32;
  localparam int unsigned X_ENC_SIZE  = 3;
  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned ENC_LATENCY = 2;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned ID_W        = 1;
  localparam int unsigned VEC_W       = DTYPE_SIZE * X_ENC_SIZE;

  localparam logic [31:0] SPLIT [X_ENC_SIZE] = '{32'h3F800000, 32'h3F000000, 32'h40000000};
  // 0.2, 0.5, 0.75, 1.0, 1.5, 2.0, 3.0, 5.0
  localparam logic [31:0] FLT [8] = '{32'h3E4CCCCD, 32'h3F000000, 32'h3F400000, 32'h3F800000,
                                      32'h3FC00000, 32'h40000000, 32'h40400000, 32'h40A00000};

  logic                        clock = 1'b0;
  logic                        reset_n = 1'b0;
  logic [NUM_REQ-1:0]          req_valid = '0;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*VEC_W-1:0]    req_x = '0;
  logic [VEC_W-1:0]            enc_x;
  logic [X_ENC_SIZE-1:0]       enc_x_enc;
  logic [X_ENC_SIZE-1:0]       cmp_q;
  logic                        out_valid;
  logic                        out_ready = 1'b0;
  logic [X_ENC_SIZE-1:0]       out_x_enc;
  logic [ID_W-1:0]             out_id;
  logic                        busy;

  always #5 clock = ~clock;

  x_encoder_arbiter #(
    .DTYPE_SIZE  (DTYPE_SIZE),
    .X_ENC_SIZE  (X_ENC_SIZE),
    .NUM_REQ     (NUM_REQ),
    .ENC_LATENCY (ENC_LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ID_W        (ID_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .enc_x     (enc_x),
    .enc_x_enc (enc_x_enc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x_enc (out_x_enc),
    .out_id    (out_id),
    .busy      (busy)
  );

  // Unsigned compare of bit patterns is exact for the non-negative floats used here.
  function automatic logic [X_ENC_SIZE-1:0] golden(input logic [VEC_W-1:0] v);
    logic [X_ENC_SIZE-1:0] r;
    r = '0;
    for (int f = 0; f < X_ENC_SIZE; f++) r[f] = (v[f*32 +: 32] > SPLIT[f]);
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] make_vec(input int unsigned seed);
    logic [VEC_W-1:0] v;
    for (int f = 0; f < X_ENC_SIZE; f++) v[f*32 +: 32] = FLT[(seed + f * 3) % 8];
    return v;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmp_q     <= '0;
      enc_x_enc <= '0;
    end else begin
      cmp_q     <= golden(enc_x);
      enc_x_enc <= cmp_q;
    end
  end

  typedef struct packed {
    logic [X_ENC_SIZE-1:0] x_enc;
    logic [ID_W-1:0]       id;
  } res_t;

  res_t             exp_q[$];
  int unsigned      grant_log[$];
  int unsigned      compared = 0;
  int unsigned      mismatched = 0;
  int unsigned      pops = 0;
  int unsigned      others [NUM_REQ];
  logic [NUM_REQ-1:0] acc_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: handshakes are sampled mid-cycle and take effect at the next rising edge.
  always @(negedge clock) begin
    res_t e;
    acc_mask = '0;
    if (reset_n) begin
      if (req_valid != '0) check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_mask[i] = 1'b1;
          exp_q.push_back('{x_enc: golden(req_x[i*VEC_W +: VEC_W]), id: ID_W'(i)});
          grant_log.push_back(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || acc_mask[i]) others[i] = 0;
        else if (acc_mask != '0) begin
          others[i]++;
          check("fairness", 32'(others[i] < NUM_REQ), 32'd1);
        end
      end
      if (dut.tag_valid[ENC_LATENCY])
        check("fifo_overflow",
              32'((dut.fifo_count == FIFO_DEPTH) && !(out_valid && out_ready)), 32'd0);
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("stale_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_x_enc", 32'(out_x_enc), 32'(e.x_enc));
          check("out_id", 32'(out_id), 32'(e.id));
        end
      end
    end
  end

  always @(negedge reset_n) begin
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) others[i] = 0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_vec(input int unsigned i, input logic [VEC_W-1:0] v);
    req_x[i*VEC_W +: VEC_W] = v;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    out_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check(name, {30'd0, busy, 1'(exp_q.size() == 0)}, 32'd1);
  endtask

  // Stream from the requesters in mask until n accepts have been seen.
  task automatic stream(input logic [NUM_REQ-1:0] mask, input int unsigned n,
                        inout int unsigned seed, input bit ready_pattern, input string name);
    int unsigned start, cyc;
    start = grant_log.size();
    cyc = 0;
    for (int i = 0; i < NUM_REQ; i++) if (mask[i]) set_vec(i, make_vec(seed++));
    req_valid = mask;
    while ((grant_log.size() - start) < n && cyc < 200) begin
      if (ready_pattern) out_ready = (cyc % 3) != 0;
      tick();
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) if (acc_mask[i]) set_vec(i, make_vec(seed++));
    end
    req_valid = '0;
    check(name, grant_log.size() - start, n);
  endtask

  initial begin
    logic [VEC_W-1:0] v1;
    int unsigned seed, start, acc, p0;
    seed = 1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enc_x", 32'(enc_x != '0), 32'd0);
    check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1. Single request {3.0, 0.2, 5.0} -> 3'b101 from requester 0, out_valid in cycle 4
    v1 = {32'h40A00000, 32'h3E4CCCCD, 32'h40400000};
    set_vec(0, v1);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    check("t1_accept", 32'(acc_mask), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      check("t1_latency", 32'(out_valid), 32'(c == 4));
      if (c < 4) tick();
    end
    check("t1_x_enc", 32'(out_x_enc), 32'b101);
    check("t1_id", 32'(out_id), 32'd0);
    check("t1_busy_hold", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_out_valid_fall", 32'(out_valid), 32'd0);

    // 2. Both requesters held: grants alternate starting at 1 (rr_ptr after test 1)
    start = grant_log.size();
    stream(2'b11, 8, seed, 1'b0, "t2_accepts");
    if (grant_log.size() >= start + 8)
      for (int k = 0; k < 8; k++) check("t2_grant_order", grant_log[start+k], (1 + k) % 2);
    drain("t2_drain");

    // 3. out_ready low: exactly FIFO_DEPTH accepts, then req_ready stays low
    out_ready = 1'b0;
    start = grant_log.size();
    set_vec(0, make_vec(seed++));
    req_valid = 2'b01;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (acc_mask[0]) set_vec(0, make_vec(seed++));
    end
    acc = grant_log.size() - start;
    check("t3_accepts", acc, FIFO_DEPTH);
    check("t3_ready_low", 32'(req_ready), 32'd0);
    req_valid = '0;
    p0 = pops;
    drain("t3_drain");
    check("t3_pop_count", pops - p0, FIFO_DEPTH);

    // 4. Push and pop in the same cycle with FIFO at DEPTH-1
    out_ready = 1'b0;
    stream(2'b01, FIFO_DEPTH, seed, 1'b0, "t4_fill");
    acc = 0;
    while (dut.fifo_count != FIFO_DEPTH - 1 && acc < 10) begin
      tick();
      acc++;
    end
    check("t4_reach_depth_m1", 32'(dut.fifo_count), FIFO_DEPTH - 1);
    check("t4_push_pending", 32'(dut.tag_valid[ENC_LATENCY]), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_push_pop_count", 32'(dut.fifo_count), FIFO_DEPTH - 1);
    drain("t4_drain");
    p0 = pops;
    stream(2'b11, 3 * FIFO_DEPTH, seed, 1'b1, "t4_wrap_accepts");
    drain("t4_wrap_drain");
    check("t4_wrap_pops", pops - p0, 3 * FIFO_DEPTH);

    // 5. Reset with 2 results in the FIFO and 2 in flight (credit limit caps the total at DEPTH)
    out_ready = 1'b0;
    stream(2'b01, FIFO_DEPTH, seed, 1'b0, "t5_fill");
    tick();
    check("t5_pre_fifo_count", 32'(dut.fifo_count), 32'd2);
    check("t5_pre_rr_ptr", 32'(dut.rr_ptr), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_enc_x", 32'(enc_x != '0), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    set_vec(0, make_vec(seed++));
    set_vec(1, make_vec(seed++));
    req_valid = 2'b11;
    out_ready = 1'b1;
    p0 = pops;
    tick();
    req_valid = '0;
    check("t5_grant_after_reset", 32'(acc_mask), 32'd1);
    drain("t5_drain");
    check("t5_pops", pops - p0, 32'd1);

    // 6. Random valid/ready traffic
    for (int i = 0; i < NUM_REQ; i++) set_vec(i, make_vec(seed++));
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i] || !req_valid[i]) begin
          if (acc_mask[i]) set_vec(i, make_vec($urandom_range(0, 255)));
          req_valid[i] = ($urandom_range(0, 3) != 0);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
